// File: rtl/s1_ctrl_pkg.sv
// Shared types and constants for the s1 counter controller slice.
package s1_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/s1_count_ctrl_if.sv
// Host-side control/status bundle of the programmable interval timer.
interface s1_count_ctrl_if
  import s1_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, periodic, limit,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, pause, periodic, limit,
    output count, busy, done
  );

endinterface

// File: rtl/s1_sync_counter.sv
// Synchronous up-counter register with clear (dominant) and count enable.
module s1_sync_counter
  import s1_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/s1_count_ctrl.sv
// Interval-timer sequencer: counts 0..limit, pulses done at terminal count,
// then stops (one-shot) or wraps (periodic); pause freezes, stop aborts.
module s1_count_ctrl
  import s1_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  s1_count_ctrl_if.slave        bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             done_reg;
  logic             done_next;
  logic             busy_reg;
  logic             latch;
  logic             clr;
  logic             en;
  logic [WIDTH-1:0] count_val;

  s1_sync_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (en),
    .count   (count_val)
  );

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          latch      = 1'b1;
          clr        = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Priority: stop, then pause, then terminal detection, then count.
        if (bus.stop) begin
          clr        = 1'b1;
          state_next = IDLE;
        end else if (bus.pause) begin
          state_next = PAUSE;
        end else if (count_val == limit_q) begin
          done_next = 1'b1;
          if (periodic_q) begin
            clr = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          en = 1'b1;
        end
      end
      PAUSE: begin
        // The resume edge only changes state; counting restarts one edge later.
        if (bus.stop) begin
          clr        = 1'b1;
          state_next = IDLE;
        end else if (!bus.pause) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        limit_q    <= bus.limit;
        periodic_q <= bus.periodic;
      end
      done_reg <= done_next;
      busy_reg <= (state_next != IDLE);
    end
  end

  assign bus.count = count_val;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_s1_count_ctrl.sv
// Scoreboard bench for s1_count_ctrl: directed per-edge expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_s1_count_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  s1_count_ctrl_if #(.WIDTH(4)) bus ();

  s1_count_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Drive one edge's inputs, then queue what the outputs must be after that edge.
  task automatic cyc(input logic st, input logic sp, input logic pa, input logic pe,
                     input logic [3:0] lim, input logic [3:0] ec, input logic eb,
                     input logic ed, input string tag);
    exp_t e;
    @(negedge clk);
    bus.start    = st;
    bus.stop     = sp;
    bus.pause    = pa;
    bus.periodic = pe;
    bus.limit    = lim;
    @(posedge clk);
    e.cnt  = ec;
    e.busy = eb;
    e.done = ed;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] ec, input logic eb, input logic ed, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, ec, eb, ed, tag);
  endtask

  // Monitor: outputs are compared every cycle an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " count"}, int'(bus.count), int'(e.cnt));
        check({e.tag, " busy"},  int'(bus.busy),  int'(e.busy));
        check({e.tag, " done"},  int'(bus.done),  int'(e.done));
        if (bus.done)
          $display("cycle %0d %s: done pulse, count=%0d busy=%0d", cycle, e.tag, bus.count, bus.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.periodic = 1'b0;
    bus.limit    = 4'd0;

    // Power-on reset state
    #12;
    check("por count", int'(bus.count), 0);
    check("por busy",  int'(bus.busy),  0);
    check("por done",  int'(bus.done),  0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4'd0, 1'b0, 1'b0, "idle after por");
    idle(4'd0, 1'b0, 1'b0, "idle after por");

    // One-shot, limit 9; a start at count 5 with another limit is ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0, "oneshot9");
    for (int n = 1; n <= 9; n++) begin
      if (n == 5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b1, 1'b0, "oneshot9 start-busy");
      else        idle(4'(n), 1'b1, 1'b0, "oneshot9");
    end
    idle(4'd9, 1'b0, 1'b1, "oneshot9 terminal");
    idle(4'd9, 1'b0, 1'b0, "oneshot9 hold");

    // Periodic, limit 3: 0,1,2,3,0,... with done every 4 edges
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, "periodic3");
    for (int k = 1; k <= 11; k++)
      idle(4'(k % 4), 1'b1, (k % 4) == 0, "periodic3");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "periodic3 stop");

    // Pause at count 2, limit 5: count frozen three extra edges, done at edge 9
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, "pause5");
    idle(4'd1, 1'b1, 1'b0, "pause5");
    idle(4'd2, 1'b1, 1'b0, "pause5");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, "pause5 enter");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, "pause5 hold");
    idle(4'd2, 1'b1, 1'b0, "pause5 resume");
    idle(4'd3, 1'b1, 1'b0, "pause5");
    idle(4'd4, 1'b1, 1'b0, "pause5");
    idle(4'd5, 1'b1, 1'b0, "pause5");
    idle(4'd5, 1'b0, 1'b1, "pause5 terminal");
    idle(4'd5, 1'b0, 1'b0, "pause5 hold");

    // start together with stop in IDLE is refused; count stays at 5
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd5, 1'b0, 1'b0, "start+stop idle");
    idle(4'd5, 1'b0, 1'b0, "start+stop idle");

    // Stop at count 4
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0, "stop4");
    for (int n = 1; n <= 4; n++) idle(4'(n), 1'b1, 1'b0, "stop4");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "stop4 abort");
    idle(4'd0, 1'b0, 1'b0, "stop4 after");

    // Stop while paused
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b1, 1'b0, "stoppause");
    idle(4'd1, 1'b1, 1'b0, "stoppause");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, "stoppause enter");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "stoppause abort");

    // Limit 0 one-shot and periodic
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "lim0 oneshot");
    idle(4'd0, 1'b0, 1'b1, "lim0 oneshot terminal");
    idle(4'd0, 1'b0, 1'b0, "lim0 oneshot after");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, "lim0 periodic");
    for (int k = 1; k <= 3; k++) idle(4'd0, 1'b1, 1'b1, "lim0 periodic");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "lim0 periodic stop");

    // Limit 15: full range without wrap, done 16 edges after start
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b1, 1'b0, "lim15");
    for (int n = 1; n <= 15; n++) idle(4'(n), 1'b1, 1'b0, "lim15");
    idle(4'd15, 1'b0, 1'b1, "lim15 terminal");
    idle(4'd15, 1'b0, 1'b0, "lim15 hold");

    // Asynchronous reset mid-run at count 5
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0, "midreset");
    for (int n = 1; n <= 4; n++) idle(4'(n), 1'b1, 1'b0, "midreset");
    @(negedge clk);
    @(posedge clk);
    #1;
    check("midreset pre count", int'(bus.count), 5);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset count", int'(bus.count), 0);
    check("midreset busy",  int'(bus.busy),  0);
    check("midreset done",  int'(bus.done),  0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4'd0, 1'b0, 1'b0, "after midreset");
    idle(4'd0, 1'b0, 1'b0, "after midreset");

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
